// File: rtl/sample_ram_pkg.sv
// Shared constants and helpers for the sample RAM controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH      - default sample width in bits
//   DEFAULT_DEPTH_LOG2 - default log2 of the RAM word count
//   count_width()      - width of an occupancy counter able to hold 0..2^d
package sample_ram_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_DEPTH_LOG2 = 13;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the pointer.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/sample_ram_ctrl_if.sv
// Capture-side / readback-side bus of the sample RAM controller.
// Latency: n/a (wiring only).
// Backpressure: none; full/empty/count tell the master what will be accepted.
//
// Signals:
//   dataInput, write, read                      - driven by the master
//   dataOutput, dataValid, count, empty, full,
//   overflow                                    - driven by the controller
interface sample_ram_ctrl_if
    import sample_ram_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);

    logic [WIDTH-1:0]                       dataInput;
    logic                                   write;
    logic                                   read;
    logic [WIDTH-1:0]                       dataOutput;
    logic                                   dataValid;
    logic [count_width(DEPTH_LOG2)-1:0]     count;
    logic                                   empty;
    logic                                   full;
    logic                                   overflow;

    modport master (
        output dataInput, write, read,
        input  dataOutput, dataValid, count, empty, full, overflow
    );

    modport slave (
        input  dataInput, write, read,
        output dataOutput, dataValid, count, empty, full, overflow
    );

endinterface

// File: rtl/sample_mem.sv
// Single-port synchronous RAM, WIDTH x 2^DEPTH_LOG2, registered read data.
// Latency: 1 cycle address -> o_q; writes land on the clock edge.
// Backpressure: none; one access per cycle, no read-during-write forwarding.
//
// Ports:
//   clock     - rising-edge clock
//   i_address - word address shared by read and write
//   i_data    - write data
//   i_wren    - write enable
//   o_q       - registered read data (old contents when written this cycle)
module sample_mem #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 13
) (
    input  logic                  clock,
    input  logic [DEPTH_LOG2-1:0] i_address,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_wren,
    output logic [WIDTH-1:0]      o_q
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // No reset on the array or q so block-RAM inference is not blocked.
    always_ff @(posedge clock) begin
        if (i_wren) begin
            r_mem[i_address] <= i_data;
        end
        r_q <= r_mem[i_address];
    end

    assign o_q = r_q;

endmodule

// File: rtl/sample_ram_ctrl.sv
// Stack-order sample store: write-up/read-down pointer over a single-port RAM.
// Latency: read -> dataValid/dataOutput 1 cycle; write -> count/flags 1 cycle.
// Backpressure: writes while full are dropped or overwrite the oldest sample
//               (SAMPLE_RAM_OVERWRITE_EN); reads while empty are ignored.
//
// Build option: define SAMPLE_RAM_OVERWRITE_EN for circular capture mode.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset, clears pointer/count/flags/output
//   bus   - sample_ram_ctrl_if.slave (dataInput/write/read in;
//           dataOutput/dataValid/count/empty/full/overflow out)
module sample_ram_ctrl
    import sample_ram_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic              clock,
    input  logic              reset,
    sample_ram_ctrl_if.slave  bus
);

    localparam int CW = count_width(DEPTH_LOG2);
    localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_dataValid;
    logic [WIDTH-1:0]      r_hold;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DEPTH_LOG2-1:0] w_ptr_dec;
    logic [DEPTH_LOG2-1:0] w_address;
    logic [WIDTH-1:0]      w_q;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_ptr_dec = r_ptr - DEPTH_LOG2'(1);

`ifdef SAMPLE_RAM_OVERWRITE_EN
    // Circular capture: every write lands; at full it replaces the oldest word,
    // which sits exactly at ptr because the stack has wrapped all the way round.
    assign w_wr_en = bus.write;
`else
    // Stop-when-full: the first DEPTH samples after the buffer emptied are kept.
    assign w_wr_en = bus.write & ~w_full;
`endif

    // Write has priority; a read in the same cycle is discarded.
    assign w_rd_en   = bus.read & ~bus.write & ~w_empty;
    assign w_address = bus.write ? r_ptr : w_ptr_dec;

    sample_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock     (clock),
        .i_address (w_address),
        .i_data    (bus.dataInput),
        .i_wren    (w_wr_en),
        .o_q       (w_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_dataValid <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_dataValid <= w_rd_en;
            // Capture the word while it is still on q; the RAM keeps reading
            // ptr-1 every cycle, so q alone would not hold the last value.
            if (r_dataValid) begin
                r_hold <= w_q;
            end
            if (bus.write && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_en) begin
                r_ptr <= r_ptr + DEPTH_LOG2'(1);
                if (!w_full) begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_rd_en) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Fresh RAM word on the valid cycle, held copy afterwards.
    assign bus.dataOutput = r_dataValid ? w_q : r_hold;
    assign bus.dataValid  = r_dataValid;
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_sample_ram_ctrl.sv
// Directed bench for sample_ram_ctrl at WIDTH=8, DEPTH_LOG2=2.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: exercises full-drop/overwrite and empty-read cases.
module tb_sample_ram_ctrl;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 2;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    sample_ram_ctrl_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus_if ();

    sample_ram_ctrl #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the currently driven inputs for one edge, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.write = 1'b0;
        bus_if.read  = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d);
        bus_if.dataInput = d;
        bus_if.write     = 1'b1;
        tick();
    endtask

    task automatic do_read(input string tag, input logic [7:0] exp_d, input logic [31:0] exp_cnt);
        bus_if.read = 1'b1;
        tick();
        chk({tag, "_vld"}, 32'(bus_if.dataValid), 32'd1);
        chk({tag, "_dat"}, 32'(bus_if.dataOutput), 32'(exp_d));
        chk({tag, "_cnt"}, 32'(bus_if.count), exp_cnt);
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        bus_if.dataInput = '0;
        bus_if.write     = 1'b0;
        bus_if.read      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_dat",   32'(bus_if.dataOutput), 32'h00);
        chk("rst_vld",   32'(bus_if.dataValid),  32'd0);
        chk("rst_cnt",   32'(bus_if.count),      32'd0);
        chk("rst_empty", 32'(bus_if.empty),      32'd1);
        chk("rst_full",  32'(bus_if.full),       32'd0);
        chk("rst_ovf",   32'(bus_if.overflow),   32'd0);

        // Three writes, then back-to-back newest-first reads
        do_write(8'h11);
        chk("w1_cnt", 32'(bus_if.count), 32'd1);
        chk("w1_empty", 32'(bus_if.empty), 32'd0);
        do_write(8'h22);
        do_write(8'h33);
        chk("w3_cnt", 32'(bus_if.count), 32'd3);
        bus_if.read = 1'b1;
        @(posedge clk); #1;
        chk("bb0_vld", 32'(bus_if.dataValid), 32'd1);
        chk("bb0_dat", 32'(bus_if.dataOutput), 32'h33);
        chk("bb0_cnt", 32'(bus_if.count), 32'd2);
        @(posedge clk); #1;
        chk("bb1_vld", 32'(bus_if.dataValid), 32'd1);
        chk("bb1_dat", 32'(bus_if.dataOutput), 32'h22);
        @(posedge clk); #1;
        bus_if.read = 1'b0;
        chk("bb2_vld", 32'(bus_if.dataValid), 32'd1);
        chk("bb2_dat", 32'(bus_if.dataOutput), 32'h11);
        chk("bb2_cnt", 32'(bus_if.count), 32'd0);
        chk("bb2_empty", 32'(bus_if.empty), 32'd1);

        // Read while empty: ignored, output holds
        bus_if.read = 1'b1;
        tick();
        chk("er_vld", 32'(bus_if.dataValid), 32'd0);
        chk("er_cnt", 32'(bus_if.count), 32'd0);
        chk("er_dat", 32'(bus_if.dataOutput), 32'h11);
        tick();
        chk("er_hold", 32'(bus_if.dataOutput), 32'h11);

        // Six writes into a 4-deep buffer
        for (int i = 1; i <= 6; i++) begin
            do_write(8'hA0 + 8'(i));
        end
        chk("of_cnt",  32'(bus_if.count),    32'd4);
        chk("of_full", 32'(bus_if.full),     32'd1);
        chk("of_ovf",  32'(bus_if.overflow), 32'd1);
`ifdef SAMPLE_RAM_OVERWRITE_EN
        do_read("of_r0", 8'hA6, 32'd3);
        do_read("of_r1", 8'hA5, 32'd2);
        do_read("of_r2", 8'hA4, 32'd1);
        do_read("of_r3", 8'hA3, 32'd0);
`else
        do_read("of_r0", 8'hA4, 32'd3);
        do_read("of_r1", 8'hA3, 32'd2);
        do_read("of_r2", 8'hA2, 32'd1);
        do_read("of_r3", 8'hA1, 32'd0);
`endif
        chk("of_empty", 32'(bus_if.empty), 32'd1);
        chk("of_ovf_sticky", 32'(bus_if.overflow), 32'd1);

        // Simultaneous write and read: write wins
        do_write(8'h44);
        bus_if.dataInput = 8'h55;
        bus_if.write     = 1'b1;
        bus_if.read      = 1'b1;
        tick();
        chk("wr_cnt", 32'(bus_if.count), 32'd2);
        chk("wr_vld", 32'(bus_if.dataValid), 32'd0);
        do_read("wr_r0", 8'h55, 32'd1);

        // Reset on the cycle after a read is sampled
        bus_if.read = 1'b1;
        tick();
        chk("rr_vld_pre", 32'(bus_if.dataValid), 32'd1);
        chk("rr_dat_pre", 32'(bus_if.dataOutput), 32'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_vld", 32'(bus_if.dataValid), 32'd0);
        chk("rr_cnt", 32'(bus_if.count), 32'd0);
        chk("rr_ovf", 32'(bus_if.overflow), 32'd0);
        chk("rr_dat", 32'(bus_if.dataOutput), 32'h00);
        chk("rr_empty", 32'(bus_if.empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
